// File: rtl/srl_fifo_pkg.sv
// Shared helpers for the SRL-backed FIFO: occupancy counter width derivation.
package srl_fifo_pkg;

  function automatic int fifo_count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/srl_fifo_if.sv
// Producer/consumer handshake bundle for srl_fifo; master drives writes and read-acks.
interface srl_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  import srl_fifo_pkg::*;

  localparam int CW = fifo_count_w(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );

endinterface

// File: rtl/srl_fifo_tap_mem.sv
// Shift-register storage with a dynamic read tap; no reset so it maps onto SRL primitives.
module srl_tap_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  // Out-of-range addr only occurs when empty, where the output is don't-care.
  assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO: occupancy counter and flags around a shift-register store.
module srl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic        clk,
  input logic        rst,
  srl_fifo_if.slave  bus
);
  import srl_fifo_pkg::*;

  localparam int             CW   = fifo_count_w(DEPTH);
  localparam int             AW   = $clog2(DEPTH);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  logic [CW-1:0] count_q;
  logic [AW-1:0] addr;
  logic          push;
  logic          pop;

  assign bus.in_ready  = (count_q != FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Newest word sits at mem[0], so the oldest is always count-1 entries deep.
  assign addr = AW'(count_q - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CW'(1);
    end
  end

  srl_tap_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .shift_en (push),
    .din      (bus.in_data),
    .addr     (addr),
    .dout     (bus.out_data)
  );

endmodule

// File: tb/tb_srl_fifo.sv
// Bench for srl_fifo at DEPTH=16 and DEPTH=33: directed scenarios plus random traffic vs a queue model.
module tb_srl_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  srl_fifo_if #(.WIDTH(8), .DEPTH(16)) a_if ();
  srl_fifo_if #(.WIDTH(8), .DEPTH(33)) b_if ();

  srl_fifo #(.WIDTH(8), .DEPTH(16)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  srl_fifo #(.WIDTH(8), .DEPTH(33)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] pop_log_a[$];
  bit         mon_en[2] = '{1'b0, 1'b0};
  bit         saw_ff = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ideal bounded queue. Sampled mid-cycle, it predicts the
  // flags of the current state and then applies this cycle's accepted transfers.
  task automatic mon(input int id, input int dep, input logic rs,
                     input logic iv, input logic [7:0] idat, input logic ir,
                     input logic ov, input logic orr, input logic [7:0] od,
                     input int cnt);
    int         sz;
    logic [7:0] exp_d;
    if (!mon_en[id]) begin
      if (rs) begin
        if (id == 0) q0.delete(); else q1.delete();
        mon_en[id] = 1'b1;
      end
      return;
    end
    sz = (id == 0) ? q0.size() : q1.size();
    chk(id == 0 ? "a_count" : "b_count", cnt, sz);
    chk(id == 0 ? "a_in_ready" : "b_in_ready", int'(ir), int'(sz != dep));
    chk(id == 0 ? "a_out_valid" : "b_out_valid", int'(ov), int'(sz != 0));
    if (rs) begin
      if (id == 0) q0.delete(); else q1.delete();
      return;
    end
    if (sz > 0 && orr) begin
      if (id == 0) exp_d = q0.pop_front(); else exp_d = q1.pop_front();
      chk(id == 0 ? "a_out_data" : "b_out_data", int'(od), int'(exp_d));
      if (id == 0) begin
        pop_log_a.push_back(od);
        if (od == 8'hFF) saw_ff = 1'b1;
      end
    end
    if (iv && sz < dep) begin
      if (id == 0) q0.push_back(idat); else q1.push_back(idat);
    end
  endtask

  always @(negedge clk)
    mon(0, 16, rst, a_if.in_valid, a_if.in_data, a_if.in_ready,
        a_if.out_valid, a_if.out_ready, a_if.out_data, int'(a_if.count));

  always @(negedge clk)
    mon(1, 33, rst, b_if.in_valid, b_if.in_data, b_if.in_ready,
        b_if.out_valid, b_if.out_ready, b_if.out_data, int'(b_if.count));

  task automatic step_a(input logic v, input logic [7:0] d, input logic r);
    a_if.in_valid  = v;
    a_if.in_data   = d;
    a_if.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sp [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};

  initial begin
    int pv;
    int pr;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_count", int'(a_if.count), 0);
    chk("reset_in_ready", int'(a_if.in_ready), 1);
    chk("reset_out_valid", int'(a_if.out_valid), 0);

    // Fill to full, then offer a word that must be refused.
    for (int i = 1; i <= 16; i++) step_a(1'b1, 8'(i), 1'b0);
    chk("fill_count", int'(a_if.count), 16);
    chk("fill_in_ready", int'(a_if.in_ready), 0);
    repeat (2) step_a(1'b1, 8'hFF, 1'b0);
    chk("full_count", int'(a_if.count), 16);

    pop_log_a.delete();
    for (int i = 0; i < 16; i++) step_a(1'b0, 8'h00, 1'b1);
    chk("drain_words", pop_log_a.size(), 16);
    for (int i = 0; i < 16 && i < pop_log_a.size(); i++)
      chk("drain_order", int'(pop_log_a[i]), i + 1);
    chk("drain_no_ff", int'(saw_ff), 0);
    chk("drain_count", int'(a_if.count), 0);
    chk("drain_out_valid", int'(a_if.out_valid), 0);

    for (int i = 0; i < 5; i++) step_a(1'b0, 8'h00, 1'b1);
    chk("empty_count", int'(a_if.count), 0);

    // Simultaneous push and pop at steady occupancy.
    for (int i = 0; i < 3; i++) step_a(1'b1, 8'hA0 + 8'(i), 1'b0);
    pop_log_a.delete();
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, 8'hB0 + 8'(i), 1'b1);
      chk("sp_count", int'(a_if.count), 3);
    end
    chk("sp_words", pop_log_a.size(), 4);
    for (int i = 0; i < 4 && i < pop_log_a.size(); i++)
      chk("sp_order", int'(pop_log_a[i]), int'(exp_sp[i]));
    for (int i = 0; i < 3; i++) step_a(1'b0, 8'h00, 1'b1);

    // Reset with traffic offered in the same cycle.
    for (int i = 0; i < 7; i++) step_a(1'b1, 8'h30 + 8'(i), 1'b0);
    chk("pre_rst_count", int'(a_if.count), 7);
    rst = 1'b1;
    step_a(1'b1, 8'h77, 1'b1);
    rst = 1'b0;
    chk("rst_count", int'(a_if.count), 0);
    chk("rst_out_valid", int'(a_if.out_valid), 0);
    chk("rst_in_ready", int'(a_if.in_ready), 1);
    step_a(1'b1, 8'h5A, 1'b0);
    chk("post_rst_valid", int'(a_if.out_valid), 1);
    chk("post_rst_data", int'(a_if.out_data), 'h5A);
    step_a(1'b0, 8'h00, 1'b1);
    chk("post_rst_count", int'(a_if.count), 0);

    // Random traffic on both depths with shifting fill/drain bias.
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        pv = 20 + 30 * int'($urandom_range(0, 2));
        pr = 20 + 30 * int'($urandom_range(0, 2));
      end
      a_if.in_valid  = ($urandom_range(0, 99) < pv);
      a_if.in_data   = 8'($urandom);
      a_if.out_ready = ($urandom_range(0, 99) < pr);
      b_if.in_valid  = ($urandom_range(0, 99) < pv);
      b_if.in_data   = 8'($urandom);
      b_if.out_ready = ($urandom_range(0, 99) < pr);
      @(posedge clk);
      #1;
    end

    a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("final_a_count", int'(a_if.count), 0);
    chk("final_b_count", int'(b_if.count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
